// File: rtl/nco_pkg.sv
// Shared types and constants for the NCO phase sequencer and its CORDIC interface.
package nco_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  localparam int unsigned ANGLE_W  = 16;
  localparam logic [ANGLE_W-1:0] QUARTER = 16'h4000;
  localparam int unsigned CORDIC_W = 32;

  typedef struct packed {
    logic [ANGLE_W-1:0]         phase;
    logic signed [CORDIC_W-1:0] cos;
    logic signed [CORDIC_W-1:0] sin;
  } entry_t;

endpackage

// File: rtl/nco_phase_sequencer_if.sv
// Valid/ready sample stream carrying {phase, cos, sin} to the downstream DSP path.
interface nco_phase_sequencer_if
  import nco_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) ();

  logic               m_valid;
  logic               m_ready;
  logic [ANGLE_W-1:0] m_phase;
  logic [DATA_W-1:0]  m_cos;
  logic [DATA_W-1:0]  m_sin;

  modport master (output m_valid, m_phase, m_cos, m_sin, input m_ready);
  modport slave  (input m_valid, m_phase, m_cos, m_sin, output m_ready);

endinterface

// File: rtl/nco_out_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
module nco_out_fifo
  import nco_pkg::*;
#(
  parameter int unsigned WIDTH = 80,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_wr;
  logic [PTR_W:0]   r_rd;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_level   = r_wr - r_rd;
  assign o_empty   = (o_level == '0);
  assign o_full    = (o_level == (PTR_W + 1)'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  // A pop frees the head slot in the same cycle, so push-while-full is fine alongside it.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[PTR_W-1:0]] <= i_data;
  end

  push_while_full_a : assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && o_full && !i_pop));

endmodule

// File: rtl/nco_phase_sequencer.sv
// Phase accumulator and CORDIC transaction sequencer; results are tagged with
// their angle and queued in an output FIFO.
module nco_phase_sequencer
  import nco_pkg::*;
#(
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [ACC_W-1:0]            fcw,
  input  logic [ANGLE_W-1:0]          phase_offset,
  input  logic                        load_phase,
  input  logic [ACC_W-1:0]            phase_init,
  output logic                        cordic_start,
  output logic [ANGLE_W-1:0]          cordic_angle,
  input  logic                        cordic_ready,
  input  logic                        cordic_done,
  input  logic [DATA_W-1:0]           cordic_cos,
  input  logic [DATA_W-1:0]           cordic_sin,
  nco_phase_sequencer_if.master       m_if,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int unsigned WD_W    = $clog2(TIMEOUT + 1);
  localparam int unsigned ENTRY_W = ANGLE_W + 2 * DATA_W;

  state_e             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [ANGLE_W-1:0] r_angle;
  logic               r_start;
  logic               r_timeout;
  logic [WD_W-1:0]    r_wd;

  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic               w_full;
  logic [ENTRY_W-1:0] w_head;

  assign w_push = (r_state == WAIT) && cordic_done;
  assign w_pop  = m_if.m_valid && m_if.m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_angle   <= '0;
      r_start   <= 1'b0;
      r_timeout <= 1'b0;
      r_wd      <= '0;
    end else begin
      r_start   <= 1'b0;
      r_timeout <= 1'b0;
      // The issued angle was captured on entry to ISSUE, so a load never disturbs it.
      if (load_phase) begin
        r_acc <= phase_init;
      end else if (r_state == ISSUE) begin
        r_acc <= r_acc + fcw;
      end
      case (r_state)
        IDLE: begin
          // Nothing is in flight here, so a free FIFO slot is the whole credit.
          if (enable && cordic_ready && !cordic_done && !w_full) begin
            r_state <= ISSUE;
            r_start <= 1'b1;
            r_angle <= r_acc[ACC_W-1 -: ANGLE_W] + phase_offset;
            r_wd    <= '0;
          end
        end
        ISSUE: begin
          r_state <= WAIT;
          r_wd    <= r_wd + 1'b1;
        end
        WAIT: begin
          if (cordic_done) begin
            r_state <= IDLE;
          end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
            r_state   <= IDLE;
            r_timeout <= 1'b1;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  nco_out_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({r_angle, cordic_cos, cordic_sin}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (fifo_level)
  );

  assign m_if.m_valid = !w_empty;
  assign m_if.m_phase = w_head[ENTRY_W-1 -: ANGLE_W];
  assign m_if.m_cos   = w_head[2*DATA_W-1 -: DATA_W];
  assign m_if.m_sin   = w_head[DATA_W-1:0];

  assign cordic_start = r_start;
  assign cordic_angle = r_angle;
  assign busy         = (r_state != IDLE);
  assign timeout_err  = r_timeout;

endmodule

// File: tb/tb_nco_phase_sequencer.sv
// Directed scoreboard bench for nco_phase_sequencer with a behavioural CORDIC model.
module tb_nco_phase_sequencer;
  import nco_pkg::*;

  localparam int LAT = 18;
  localparam int TOL = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] fcw = '0;
  logic [15:0] phase_offset = '0;
  logic        load_phase = 1'b0;
  logic [31:0] phase_init = '0;
  logic        cordic_start;
  logic [15:0] cordic_angle;
  logic        cordic_ready;
  logic        cordic_done;
  logic [31:0] cordic_cos;
  logic [31:0] cordic_sin;
  logic [2:0]  fifo_level;
  logic        busy;
  logic        timeout_err;

  nco_phase_sequencer_if #(.DATA_W(32)) m_if ();

  nco_phase_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .fcw          (fcw),
    .phase_offset (phase_offset),
    .load_phase   (load_phase),
    .phase_init   (phase_init),
    .cordic_start (cordic_start),
    .cordic_angle (cordic_angle),
    .cordic_ready (cordic_ready),
    .cordic_done  (cordic_done),
    .cordic_cos   (cordic_cos),
    .cordic_sin   (cordic_sin),
    .m_if         (m_if),
    .fifo_level   (fifo_level),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail = 0;
  int     cyc = 0;
  int     n_starts = 0;
  int     n_timeouts = 0;
  int     last_start = 0;
  int     to_delta = -1;
  logic   drop_next = 1'b0;
  entry_t sb[$];

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic check_tol(input string name, input int act, input int req);
    int d;
    n_checks++;
    d = act - req;
    if (d > TOL || d < -TOL) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d +/- %0d", name, act, req, TOL);
    end
  endtask

  function automatic logic [31:0] q16(input logic [15:0] a, input bit is_sin);
    real th;
    real r;
    th = 6.283185307179586 * real'(a) / 65536.0;
    r  = (is_sin ? $sin(th) : $cos(th)) * 65536.0;
    return 32'($rtoi(r + ((r >= 0.0) ? 0.5 : -0.5)));
  endfunction

  // CORDIC model: busy for LAT cycles after a start, optionally swallowing the result.
  logic        mdl_busy;
  logic        mdl_drop;
  int          mdl_cnt;
  logic [15:0] mdl_angle;

  assign cordic_ready = !mdl_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_busy    <= 1'b0;
      mdl_drop    <= 1'b0;
      mdl_cnt     <= 0;
      mdl_angle   <= '0;
      cordic_done <= 1'b0;
      cordic_cos  <= '0;
      cordic_sin  <= '0;
    end else begin
      cordic_done <= 1'b0;
      if (mdl_busy) begin
        if (mdl_cnt == 1) begin
          mdl_busy <= 1'b0;
          if (!mdl_drop) begin
            cordic_done <= 1'b1;
            cordic_cos  <= q16(mdl_angle, 1'b0);
            cordic_sin  <= q16(mdl_angle, 1'b1);
          end
        end else begin
          mdl_cnt <= mdl_cnt - 1;
        end
      end else if (cordic_start) begin
        mdl_busy  <= 1'b1;
        mdl_cnt   <= LAT;
        mdl_angle <= cordic_angle;
        mdl_drop  <= drop_next;
      end
    end
  end

  // Monitor: observes events and pops the scoreboard on every accepted output beat.
  always begin
    entry_t e;
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      if (cordic_start) begin
        n_starts++;
        last_start = cyc;
      end
      if (timeout_err) begin
        n_timeouts++;
        to_delta = cyc - last_start;
      end
      if (cordic_done) check("cordic_angle_stable", cordic_angle, mdl_angle);
      if (m_if.m_valid && m_if.m_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: phase 0x%0h delivered, no entry expected", m_if.m_phase);
        end else begin
          e = sb.pop_front();
          check("m_phase", m_if.m_phase, e.phase);
          check_tol("m_cos", $signed(m_if.m_cos), e.cos);
          check_tol("m_sin", $signed(m_if.m_sin), e.sin);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [31:0] v);
    phase_init = v;
    load_phase = 1'b1;
    step(1);
    load_phase = 1'b0;
  endtask

  task automatic exp_push(input logic [15:0] ph, input int c, input int s);
    entry_t e;
    e.phase = ph;
    e.cos   = c;
    e.sin   = s;
    sb.push_back(e);
  endtask

  task automatic wait_starts(input int target, input int budget, input string name);
    for (int i = 0; i < budget && n_starts < target; i++) step(1);
    check(name, longint'(n_starts >= target), 1);
  endtask

  task automatic wait_drain(input int budget, input string name);
    for (int i = 0; i < budget && (sb.size() != 0 || busy || m_if.m_valid); i++) step(1);
    check(name, longint'(sb.size() == 0 && !busy && !m_if.m_valid), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_m_valid"}, m_if.m_valid, 0);
    check({tag, "_fifo_level"}, fifo_level, 0);
    check({tag, "_cordic_start"}, cordic_start, 0);
    check({tag, "_cordic_angle"}, cordic_angle, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    int base;
    int t0;
    m_if.m_ready = 1'b0;
    step(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step(1);

    // 1: quarter-turn stepping, free-flowing output
    fcw = 32'h4000_0000;
    m_if.m_ready = 1'b1;
    exp_push(16'h0000, 65536, 0);
    exp_push(16'h4000, 0, 65536);
    exp_push(16'h8000, -65536, 0);
    exp_push(16'hC000, 0, -65536);
    exp_push(16'h0000, 65536, 0);
    base = n_starts;
    enable = 1'b1;
    wait_starts(base + 5, 400, "t1_starts");
    enable = 1'b0;
    wait_drain(200, "t1_drain");

    // 2: back-pressure fills the FIFO and stalls issue, then drains in order
    load(32'h0);
    m_if.m_ready = 1'b0;
    exp_push(16'h0000, 65536, 0);
    exp_push(16'h4000, 0, 65536);
    exp_push(16'h8000, -65536, 0);
    exp_push(16'hC000, 0, -65536);
    exp_push(16'h0000, 65536, 0);
    exp_push(16'h4000, 0, 65536);
    base = n_starts;
    enable = 1'b1;
    for (int i = 0; i < 300 && fifo_level != 3'd4; i++) step(1);
    step(60);
    check("t2_starts_stalled", n_starts - base, 4);
    check("t2_level_full", fifo_level, 4);
    check("t2_valid_full", m_if.m_valid, 1);
    check("t2_idle_when_full", busy, 0);
    m_if.m_ready = 1'b1;
    wait_starts(base + 6, 400, "t2_starts");
    enable = 1'b0;
    wait_drain(200, "t2_drain");

    // 3: accumulator wrap across 2^32
    fcw = 32'h0002_0000;
    load(32'hFFFF_0000);
    exp_push(16'hFFFF, 65536, 0);
    exp_push(16'h0001, 65536, 0);
    exp_push(16'h0003, 65536, 0);
    base = n_starts;
    enable = 1'b1;
    wait_starts(base + 3, 300, "t3_starts");
    enable = 1'b0;
    wait_drain(200, "t3_drain");

    // 3b: load during ISSUE wins over the advance
    fcw = 32'h4000_0000;
    load(32'h0);
    exp_push(16'h0000, 65536, 0);
    exp_push(16'h8000, -65536, 0);
    exp_push(16'hC000, 0, -65536);
    base = n_starts;
    enable = 1'b1;
    for (int i = 0; i < 50 && !cordic_start; i++) step(1);
    check("t3b_issue_seen", cordic_start, 1);
    phase_init = 32'h8000_0000;
    load_phase = 1'b1;
    step(1);
    load_phase = 1'b0;
    wait_starts(base + 3, 300, "t3b_starts");
    enable = 1'b0;
    wait_drain(200, "t3b_drain");

    // 4: constant phase through the offset
    fcw = 32'h0;
    phase_offset = QUARTER;
    load(32'h0);
    repeat (3) exp_push(16'h4000, 0, 65536);
    base = n_starts;
    enable = 1'b1;
    wait_starts(base + 3, 300, "t4_starts");
    enable = 1'b0;
    wait_drain(200, "t4_drain");
    phase_offset = '0;

    // 5: dropped result trips the watchdog; the next sample still flows
    fcw = 32'h4000_0000;
    load(32'h0);
    exp_push(16'h4000, 0, 65536);
    exp_push(16'h8000, -65536, 0);
    t0 = n_timeouts;
    base = n_starts;
    drop_next = 1'b1;
    enable = 1'b1;
    wait_starts(base + 1, 50, "t5_first_start");
    drop_next = 1'b0;
    for (int i = 0; i < 120 && n_timeouts == t0; i++) step(1);
    check("t5_timeout_seen", n_timeouts - t0, 1);
    check("t5_timeout_delay", to_delta, 64);
    check("t5_no_push", fifo_level, 0);
    wait_starts(base + 3, 300, "t5_starts");
    enable = 1'b0;
    wait_drain(200, "t5_drain");
    check("t5_single_pulse", n_timeouts - t0, 1);

    // 6: asynchronous reset during WAIT discards FIFO and in-flight result
    load(32'h0);
    m_if.m_ready = 1'b0;
    base = n_starts;
    enable = 1'b1;
    wait_starts(base + 2, 200, "t6_starts");
    step(5);
    check("t6_level_before_reset", fifo_level, 1);
    check("t6_busy_before_reset", busy, 1);
    rst_n = 1'b0;
    enable = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);
    check_reset_outputs("t6");
    m_if.m_ready = 1'b1;
    step(50);
    check("t6_still_empty", m_if.m_valid, 0);
    check("t6_level_zero", fifo_level, 0);
    exp_push(16'h0000, 65536, 0);
    base = n_starts;
    enable = 1'b1;
    wait_starts(base + 1, 50, "t6_restart");
    enable = 1'b0;
    wait_drain(200, "t6_drain");

    check("total_timeouts", n_timeouts, 1);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not complete, required completion before 500000");
    $fatal(1);
  end

endmodule
